// File: rtl/hist2d_if.sv
// hist2d_if: control, sample-stream and readout signals of hist2d_accumulate.
//   start_clear, i/q_bin_num : clear request and active bin counts
//   coord_valid/coord_ready, i/q_bin_coord : sample stream handshake
//   dump_req, out_valid/out_ready, out_i/out_q/out_count/out_last : readout
//   oor_count, total_count, busy : status
// The slave modport is the histogram block; the master modport drives it.
interface hist2d_if #(parameter int CNT_W = 16) ();
    logic             start_clear;
    logic [5:0]       i_bin_num;
    logic [5:0]       q_bin_num;
    logic             coord_valid;
    logic             coord_ready;
    logic [5:0]       i_bin_coord;
    logic [5:0]       q_bin_coord;
    logic             dump_req;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_i;
    logic [5:0]       out_q;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic [CNT_W-1:0] oor_count;
    logic [CNT_W-1:0] total_count;
    logic             busy;

    modport slave (
        input  start_clear, i_bin_num, q_bin_num, coord_valid, i_bin_coord, q_bin_coord,
               dump_req, out_ready,
        output coord_ready, out_valid, out_i, out_q, out_count, out_last,
               oor_count, total_count, busy
    );

    modport master (
        output start_clear, i_bin_num, q_bin_num, coord_valid, i_bin_coord, q_bin_coord,
               dump_req, out_ready,
        input  coord_ready, out_valid, out_i, out_q, out_count, out_last,
               oor_count, total_count, busy
    );
endinterface

// File: rtl/hist2d_accumulate.sv
// hist2d_accumulate: 2-D histogram of streamed (i,q) bin coordinates with readout.
//   clk100  : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : hist2d_if slave (clear, sample stream, dump readout, status)
// The bus interface CNT_W must match this module's CNT_W.
module hist2d_accumulate #(
    parameter int I_DIM = 8,
    parameter int Q_DIM = 8,
    parameter int CNT_W = 16
) (
    input  logic     clk100,
    input  logic     reset_n,
    hist2d_if.slave  bus
);
    localparam int IW = $clog2(I_DIM);
    localparam int QW = $clog2(Q_DIM);
    localparam int AW = IW + QW;
    localparam int NB = I_DIM * Q_DIM;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] ACCUM = 2'd2;
    localparam logic [1:0] DUMP  = 2'd3;

    logic [1:0]       state;
    logic [AW-1:0]    clr_idx;
    logic [6:0]       ni, nq;
    logic [CNT_W-1:0] mem [NB];
    logic [CNT_W-1:0] oor_cnt, tot_cnt;
    logic [5:0]       rd_i, rd_q, nxt_i, nxt_q;
    logic             rd_valid, rd_last;
    logic             accept, in_range, xfer, q_wrap;
    logic [AW-1:0]    acc_idx, rd_idx;

    function automatic logic [6:0] clamp(input logic [5:0] v, input int dim);
        return (v == 6'd0) ? 7'd1 : ({1'b0, v} > 7'(dim)) ? 7'(dim) : {1'b0, v};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // 63 is the out-of-range marker even when a dimension is 64
    assign accept   = (state == ACCUM) && bus.coord_valid;
    assign in_range = ({1'b0, bus.i_bin_coord} < ni) && ({1'b0, bus.q_bin_coord} < nq) &&
                      (bus.i_bin_coord != 6'd63) && (bus.q_bin_coord != 6'd63);
    assign acc_idx  = {bus.i_bin_coord[IW-1:0], bus.q_bin_coord[QW-1:0]};
    assign rd_idx   = {rd_i[IW-1:0], rd_q[QW-1:0]};
    assign xfer     = rd_valid && bus.out_ready;
    assign q_wrap   = ({1'b0, rd_q} == nq - 7'd1);
    assign nxt_q    = q_wrap ? 6'd0 : rd_q + 6'd1;
    assign nxt_i    = q_wrap ? rd_i + 6'd1 : rd_i;

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_idx  <= '0;
            ni       <= 7'(I_DIM);
            nq       <= 7'(Q_DIM);
            oor_cnt  <= '0;
            tot_cnt  <= '0;
            rd_i     <= '0;
            rd_q     <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (bus.start_clear) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            ni       <= clamp(bus.i_bin_num, I_DIM);
            nq       <= clamp(bus.q_bin_num, Q_DIM);
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (state == IDLE) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            if (clr_idx == '0) begin
                oor_cnt <= '0;
                tot_cnt <= '0;
            end
            clr_idx <= clr_idx + AW'(1);
            if (clr_idx == AW'(NB - 1))
                state <= ACCUM;
        end else if (state == ACCUM) begin
            if (accept) begin
                tot_cnt <= sat_inc(tot_cnt);
                if (!in_range)
                    oor_cnt <= sat_inc(oor_cnt);
            end
            if (bus.dump_req) begin
                state    <= DUMP;
                rd_i     <= '0;
                rd_q     <= '0;
                rd_valid <= 1'b1;
                rd_last  <= (ni == 7'd1) && (nq == 7'd1);
            end
        end else if (xfer) begin
            if (rd_last) begin
                state    <= ACCUM;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else begin
                rd_i    <= nxt_i;
                rd_q    <= nxt_q;
                rd_last <= ({1'b0, nxt_i} == ni - 7'd1) && ({1'b0, nxt_q} == nq - 7'd1);
            end
        end
    end

    // Bin memory is rebuilt by CLEAR after every reset, so it carries no reset
    always_ff @(posedge clk100) begin
        if (state == CLEAR)
            mem[clr_idx] <= '0;
        else if (accept && in_range)
            mem[acc_idx] <= sat_inc(mem[acc_idx]);
    end

    // Memory is never written during DUMP, so a direct read stays stable under stalls
    assign bus.out_count   = rd_valid ? mem[rd_idx] : '0;
    assign bus.out_valid   = rd_valid;
    assign bus.out_last    = rd_last;
    assign bus.out_i       = rd_i;
    assign bus.out_q       = rd_q;
    assign bus.coord_ready = (state == ACCUM);
    assign bus.busy        = (state == CLEAR) || (state == DUMP);
    assign bus.oor_count   = oor_cnt;
    assign bus.total_count = tot_cnt;
endmodule

// File: tb/tb_hist2d_accumulate.sv
// tb_hist2d_accumulate: self-checking bench for hist2d_accumulate (8x8/16-bit and 8x8/4-bit).
module tb_hist2d_accumulate;
    localparam int CMAX = 65535;

    logic clk100 = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk100 = ~clk100;

    hist2d_if #(.CNT_W(16)) b0 ();
    hist2d_if #(.CNT_W(4))  b1 ();

    hist2d_accumulate #(.I_DIM(8), .Q_DIM(8), .CNT_W(16)) u0 (
        .clk100(clk100), .reset_n(reset_n), .bus(b0.slave));
    hist2d_accumulate #(.I_DIM(8), .Q_DIM(8), .CNT_W(4)) u1 (
        .clk100(clk100), .reset_n(reset_n), .bus(b1.slave));

    int n_pass = 0;
    int n_total = 0;

    int mh [8][8];
    int moor = 0, mtot = 0, mni = 8, mnq = 8;

    typedef struct {
        int i;
        int q;
        int tot;
        int oor;
    } vec_t;
    vec_t tv [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int clampd(input int v, input int d);
        return v < 1 ? 1 : (v > d ? d : v);
    endfunction

    task automatic model_clear(input int ni, input int nq);
        foreach (mh[a, b]) mh[a][b] = 0;
        moor = 0;
        mtot = 0;
        mni = clampd(ni, 8);
        mnq = clampd(nq, 8);
    endtask

    task automatic model_accept(input int i, input int q);
        mtot = (mtot < CMAX) ? mtot + 1 : CMAX;
        if (i < mni && q < mnq) mh[i][q] = (mh[i][q] < CMAX) ? mh[i][q] + 1 : CMAX;
        else moor = (moor < CMAX) ? moor + 1 : CMAX;
    endtask

    function automatic logic [63:0] word0();
        return {34'd0, b0.out_valid, b0.out_last, b0.out_i, b0.out_q, b0.out_count};
    endfunction

    task automatic send(input int i, input int q);
        b0.coord_valid = 1'b1;
        b0.i_bin_coord = 6'(i);
        b0.q_bin_coord = 6'(q);
        if (b0.coord_ready) model_accept(i, q);
        @(negedge clk100);
        b0.coord_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!b0.coord_ready && g < 300) begin
            @(negedge clk100);
            g++;
        end
        b0.coord_valid = 1'b0;
        chk("clear_done", 64'(b0.coord_ready), 64'd1);
    endtask

    task automatic check_totals(input string name);
        chk({name, "_total"}, 64'(b0.total_count), 64'(mtot));
        chk({name, "_oor"}, 64'(b0.oor_count), 64'(moor));
    endtask

    task automatic do_clear(input int ni, input int nq, input bit hold_valid);
        b0.start_clear = 1'b1;
        b0.i_bin_num = 6'(ni);
        b0.q_bin_num = 6'(nq);
        if (hold_valid) begin
            b0.coord_valid = 1'b1;
            b0.i_bin_coord = 6'd0;
            b0.q_bin_coord = 6'd0;
        end
        @(negedge clk100);
        b0.start_clear = 1'b0;
        model_clear(ni, nq);
        chk("clear_busy", 64'(b0.busy), 64'd1);
        wait_ready();
        check_totals("after_clear");
    endtask

    task automatic dump_check(input int stall_at, input bit rnd);
        int n = 0, ei = 0, eq = 0, guard = 0, len;
        bit stalled = 1'b0;
        logic [63:0] expw;
        b0.dump_req = 1'b1;
        @(negedge clk100);
        b0.dump_req = 1'b0;
        chk("dump_first_valid", 64'(b0.out_valid), 64'd1);
        while (n < mni * mnq && guard < 4000) begin
            guard++;
            expw = {34'd0, 1'b1, 1'(ei == mni - 1 && eq == mnq - 1), 6'(ei), 6'(eq), 16'(mh[ei][eq])};
            if ((n == stall_at && !stalled) || (rnd && $urandom_range(0, 3) == 0)) begin
                len = (n == stall_at && !stalled) ? 5 : 1;
                if (n == stall_at) stalled = 1'b1;
                b0.out_ready = 1'b0;
                for (int k = 0; k < len; k++) begin
                    @(negedge clk100);
                    chk("dump_hold", word0(), expw);
                end
            end else begin
                chk("dump_word", word0(), expw);
                b0.out_ready = 1'b1;
                @(negedge clk100);
                b0.out_ready = 1'b0;
                n++;
                eq++;
                if (eq == mnq) begin
                    eq = 0;
                    ei++;
                end
            end
        end
        chk("dump_word_count", 64'(n), 64'(mni * mnq));
        chk("dump_end_valid", 64'(b0.out_valid), 64'd0);
        chk("dump_end_ready", 64'(b0.coord_ready), 64'd1);
    endtask

    initial begin
        int cnt, g, w, seen;
        bit last;
        {b0.start_clear, b0.i_bin_num, b0.q_bin_num, b0.coord_valid} = '0;
        {b0.i_bin_coord, b0.q_bin_coord, b0.dump_req, b0.out_ready} = '0;
        {b1.start_clear, b1.i_bin_num, b1.q_bin_num, b1.coord_valid} = '0;
        {b1.i_bin_coord, b1.q_bin_coord, b1.dump_req, b1.out_ready} = '0;
        model_clear(8, 8);

        tv[0] = '{1, 2, 1, 0};
        tv[1] = '{1, 2, 2, 0};
        tv[2] = '{1, 2, 3, 0};
        tv[3] = '{3, 3, 4, 0};
        tv[4] = '{5, 0, 5, 1};
        tv[5] = '{63, 63, 6, 2};

        repeat (2) @(negedge clk100);
        chk("rst_busy", 64'(b0.busy), 64'd0);
        chk("rst_ready", 64'(b0.coord_ready), 64'd0);
        chk("rst_valid", 64'(b0.out_valid), 64'd0);
        chk("rst_last", 64'(b0.out_last), 64'd0);
        chk("rst_count", 64'(b0.out_count), 64'd0);
        chk("rst_total", 64'(b0.total_count), 64'd0);
        chk("rst_oor", 64'(b0.oor_count), 64'd0);

        reset_n = 1'b1;
        cnt = 0;
        g = 0;
        while (!b0.coord_ready && g < 300) begin
            @(negedge clk100);
            g++;
            if (b0.busy) cnt++;
        end
        chk("boot_busy_cycles", 64'(cnt), 64'd64);
        check_totals("boot");
        dump_check(-1, 1'b0);

        do_clear(4, 4, 1'b0);
        for (int v = 0; v < 6; v++) begin
            send(tv[v].i, tv[v].q);
            chk("vec_total", 64'(b0.total_count), 64'(tv[v].tot));
            chk("vec_oor", 64'(b0.oor_count), 64'(tv[v].oor));
        end
        dump_check(-1, 1'b0);
        check_totals("after_dump");

        do_clear(0, 63, 1'b0);
        send(0, 5);
        send(0, 7);
        send(0, 7);
        send(1, 0);
        send(0, 8);
        check_totals("clamp");
        dump_check(-1, 1'b0);

        do_clear(6, 5, 1'b1);
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk100);
            else begin
                w = int'($urandom_range(0, 9));
                send(w == 9 ? 63 : w, int'($urandom_range(0, 7)));
            end
        end
        check_totals("random");
        dump_check(3, 1'b1);
        send(2, 2);
        check_totals("resume");
        dump_check(-1, 1'b0);

        b0.start_clear = 1'b1;
        b0.dump_req = 1'b1;
        b0.i_bin_num = 6'd8;
        b0.q_bin_num = 6'd8;
        @(negedge clk100);
        b0.start_clear = 1'b0;
        b0.dump_req = 1'b0;
        model_clear(8, 8);
        chk("both_busy", 64'(b0.busy), 64'd1);
        chk("both_ready", 64'(b0.coord_ready), 64'd0);
        seen = 0;
        repeat (5) begin
            @(negedge clk100);
            seen += int'(b0.out_valid);
        end
        b0.dump_req = 1'b1;
        @(negedge clk100);
        b0.dump_req = 1'b0;
        g = 0;
        while (!b0.coord_ready && g < 300) begin
            seen += int'(b0.out_valid);
            @(negedge clk100);
            g++;
        end
        @(negedge clk100);
        seen += int'(b0.out_valid);
        chk("no_valid_in_clear", 64'(seen), 64'd0);
        chk("clear_then_accum", 64'(b0.coord_ready), 64'd1);
        check_totals("both");

        send(1, 1);
        b0.dump_req = 1'b1;
        @(negedge clk100);
        b0.dump_req = 1'b0;
        chk("abort_valid_before", 64'(b0.out_valid), 64'd1);
        b0.start_clear = 1'b1;
        b0.i_bin_num = 6'd4;
        b0.q_bin_num = 6'd4;
        @(negedge clk100);
        b0.start_clear = 1'b0;
        model_clear(4, 4);
        chk("abort_valid_after", 64'(b0.out_valid), 64'd0);
        chk("abort_busy", 64'(b0.busy), 64'd1);
        wait_ready();
        send(3, 0);
        send(0, 3);
        send(4, 4);
        check_totals("post_abort");

        b0.dump_req = 1'b1;
        @(negedge clk100);
        b0.dump_req = 1'b0;
        b0.out_ready = 1'b1;
        repeat (2) @(negedge clk100);
        b0.out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 64'(b0.out_valid), 64'd0);
        chk("async_busy", 64'(b0.busy), 64'd0);
        chk("async_ready", 64'(b0.coord_ready), 64'd0);
        chk("async_count", 64'(b0.out_count), 64'd0);
        chk("async_total", 64'(b0.total_count), 64'd0);
        repeat (2) @(negedge clk100);
        reset_n = 1'b1;
        model_clear(8, 8);
        @(negedge clk100);
        chk("rerst_busy", 64'(b0.busy), 64'd1);
        wait_ready();
        check_totals("rerst");
        dump_check(-1, 1'b0);

        b1.coord_valid = 1'b1;
        repeat (20) @(negedge clk100);
        b1.coord_valid = 1'b0;
        chk("sat_total", 64'(b1.total_count), 64'd15);
        chk("sat_oor", 64'(b1.oor_count), 64'd0);
        b1.dump_req = 1'b1;
        @(negedge clk100);
        b1.dump_req = 1'b0;
        chk("sat_word0", {34'd0, b1.out_valid, b1.out_i, b1.out_q, b1.out_count},
            {34'd0, 1'b1, 6'd0, 6'd0, 4'd15});
        b1.out_ready = 1'b1;
        w = 0;
        g = 0;
        last = 1'b0;
        while (!last && g < 200) begin
            if (b1.out_valid) w++;
            last = b1.out_valid && b1.out_last;
            @(negedge clk100);
            g++;
        end
        b1.out_ready = 1'b0;
        chk("sat_dump_words", 64'(w), 64'd64);
        chk("sat_dump_end", 64'(b1.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/hist2d_accumulate.md
HIST2D_ACCUMULATE -- requirements
Module: hist2d_accumulate

Interface
REQ-001 SHALL have parameter I_DIM, default 8, giving the maximum number of i bins (power of two).
REQ-002 SHALL have parameter Q_DIM, default 8, giving the maximum number of q bins (power of two).
REQ-003 SHALL have parameter CNT_W, default 16, giving the count width per bin.
REQ-004 SHALL have port clk100, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start_clear, input, 1 bit: pulse that latches the bin counts and zeroes the histogram.
REQ-007 SHALL have ports i_bin_num and q_bin_num, input, 6 bits each: the active bin counts, latched on start_clear.
REQ-008 SHALL have port coord_valid, input, 1 bit: a streamed bin coordinate pair is present.
REQ-009 SHALL have port coord_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-010 SHALL have ports i_bin_coord and q_bin_coord, input, 6 bits each: bin coordinates; value 63 means out of range.
REQ-011 SHALL have port dump_req, input, 1 bit: pulse that requests histogram readout.
REQ-012 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: the readout handshake.
REQ-013 SHALL have ports out_i and out_q, output, 6 bits each: the coordinate of the bin being read out.
REQ-014 SHALL have port out_count, output, CNT_W bits: the count of the bin being read out.
REQ-015 SHALL have port out_last, output, 1 bit: marks the final readout word.
REQ-016 SHALL have ports oor_count and total_count, output, CNT_W bits each: the out-of-range and accepted-sample totals.
REQ-017 SHALL have port busy, output, 1 bit: high in CLEAR or DUMP.

Function
REQ-018 SHALL implement an FSM with states IDLE, CLEAR, ACCUM and DUMP.
REQ-019 SHALL go IDLE->CLEAR on the first clock after reset release.
REQ-020 SHALL, in CLEAR, zero one bin per cycle, in order index 0..I_DIM*Q_DIM-1, with the bin index being i*Q_DIM+q.
REQ-021 SHALL zero oor_count and total_count in the first CLEAR cycle, then enter ACCUM after the last index.
REQ-022 SHALL latch bin counts with clamping: a value of 0 becomes 1, and a value above the dimension becomes I_DIM or Q_DIM.
REQ-023 SHALL drive coord_ready = 1 only in ACCUM; a pair is accepted when coord_valid && coord_ready.
REQ-024 SHALL, on an accepted pair with i<i_bin_num_l and q<q_bin_num_l, increment bin[i][q], visible one cycle later.
REQ-025 SHALL, on any other accepted pair (including 63), increment oor_count instead.
REQ-026 SHALL increment total_count on every accepted pair.
REQ-027 SHALL make every counter saturate at all-ones and never wrap.
REQ-028 SHALL ignore coord_valid while coord_ready=0; ignored pairs are not counted.
REQ-029 SHALL, on dump_req in ACCUM, enter DUMP; the readout index starts at (0,0) and steps q fastest, over i<i_bin_num_l and q<q_bin_num_l only.
REQ-030 SHALL raise out_valid in the first DUMP cycle with out_i, out_q and out_count for the current index.
REQ-031 SHALL hold out_i, out_q, out_count, out_last and out_valid stable while out_valid && !out_ready.
REQ-032 SHALL advance the readout on out_valid && out_ready; back-to-back transfers at one per cycle are required.
REQ-033 SHALL assert out_last with the word (i_bin_num_l-1, q_bin_num_l-1), then return to ACCUM with out_valid=0 on the cycle after that transfer.
REQ-034 SHALL leave histogram contents unchanged after a dump; accumulation resumes.
REQ-035 SHALL give start_clear priority in any state: it aborts DUMP (out_valid drops next cycle) or restarts CLEAR from index 0.
REQ-036 SHALL give start_clear priority over dump_req when both arrive in the same cycle.
REQ-037 SHALL ignore dump_req in IDLE, CLEAR and DUMP.
REQ-038 SHALL drive busy = 1 in CLEAR and DUMP, and 0 otherwise.

Reset
REQ-039 SHALL, on reset_n low at any time, immediately set the state to IDLE and drive coord_ready, out_valid, out_last and busy to 0.
REQ-040 SHALL, on reset_n low, set out_i, out_q, out_count, oor_count and total_count to 0, and latched bin counts to I_DIM/Q_DIM.
REQ-041 SHALL treat bin memory as invalid after reset and rebuild it through the automatic CLEAR; no reset of the memory array is needed.

Verification
REQ-042 SHALL cover: reset release -> busy=1 for 64 cycles (8x8), then coord_ready=1 and all counts 0.
REQ-043 SHALL cover: bins 4x4, pairs (1,2)x3, (3,3)x1, (5,0)x1, (63,63)x1, then dump -> 16 words with bin(1,2)=3, bin(3,3)=1, the rest 0, out_last on (3,3), oor_count=2, total_count=6.
REQ-044 SHALL cover: out_ready held low for 5 cycles mid-dump -> outputs stable and no word lost or duplicated.
REQ-045 SHALL cover: CNT_W=4 with 20 hits on (0,0) -> count 15 and total_count 15.
REQ-046 SHALL cover: start_clear and dump_req in the same cycle during ACCUM -> CLEAR entered and no out_valid.
REQ-047 SHALL cover: reset_n pulsed low mid-DUMP -> out_valid=0 asynchronously, then re-CLEAR and all counts 0.
